// File: rtl/rr_slot_arbiter_pkg.sv
// Shared FSM state encoding and width helper for the round-robin slot arbiter.
package rr_slot_arbiter_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } arb_state_e;

  // Index width for n requesters, never below one bit.
  function automatic int unsigned id_width(int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_slot_arbiter_slot_counter.sv
// Tenure counter: synchronous reset and clear, increments while enabled.
module rr_slot_arbiter_slot_counter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [N-1:0] q
);

  logic [N-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + N'(1);
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/rr_slot_arbiter.sv
// Round-robin time-slice arbiter: registered one-hot grant, owner preempted
// when its tenure reaches QUANTUM cycles.
module rr_slot_arbiter
  import rr_slot_arbiter_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned N       = 2,
  parameter int unsigned QUANTUM = 4,
  localparam int unsigned IdW    = id_width(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IdW-1:0]  gnt_id,
  output logic            busy,
  output logic [N-1:0]    count,
  output logic            expired
);

  localparam logic [N-1:0] LastCnt = N'(QUANTUM - 1);

  arb_state_e      state_q, state_d;
  logic [IdW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IdW-1:0]  gnt_id_q, gnt_id_d;
  logic            expired_q, expired_d;

  logic            owner_req;
  logic [IdW-1:0]  next_owner;
  logic [IdW-1:0]  base;
  logic            sel_valid;
  logic [IdW-1:0]  sel_idx;
  logic            cnt_en;

  assign owner_req  = req[gnt_id_q];
  assign next_owner = (gnt_id_q == IdW'(NREQ - 1)) ? '0 : gnt_id_q + IdW'(1);
  // While busy any re-selection (release or expiry) starts just past the owner.
  assign base       = (state_q == StBusy) ? next_owner : ptr_q;

  // Rotate-priority search; reverse loop so the smallest offset from base wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      logic [IdW-1:0] idx;
      idx = IdW'((int'(base) + k) % NREQ);
      if (req[idx]) begin
        sel_valid = 1'b1;
        sel_idx   = idx;
      end
    end
  end

  assign cnt_en = (state_q == StBusy) && owner_req && (count != LastCnt);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    expired_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sel_valid) begin
          state_d  = StBusy;
          gnt_d    = NREQ'(1) << sel_idx;
          gnt_id_d = sel_idx;
        end
      end
      StBusy: begin
        if (!owner_req || count == LastCnt) begin
          // Release takes precedence over a coincident expiry.
          expired_d = owner_req;
          ptr_d     = next_owner;
          if (sel_valid) begin
            gnt_d    = NREQ'(1) << sel_idx;
            gnt_id_d = sel_idx;
          end else begin
            state_d  = StIdle;
            gnt_d    = '0;
            gnt_id_d = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      expired_q <= expired_d;
    end
  end

  rr_slot_arbiter_slot_counter #(
    .N(N)
  ) u_slot_counter (
    .clk(clk),
    .rst(rst),
    .clr(!cnt_en),
    .en (cnt_en),
    .q  (count)
  );

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = (state_q == StBusy);
  assign expired = expired_q;

endmodule
